// File: rtl/uart_cmd_resp_pkg.sv
// Shared constants and state encoding for the UART command/response engine.
package uart_cmd_resp_pkg;

    localparam logic [7:0] HDR_REQ = 8'hA5;
    localparam logic [7:0] HDR_RSP = 8'h5A;
    localparam logic [7:0] CMD_WR  = 8'h01;
    localparam logic [7:0] CMD_RD  = 8'h02;
    localparam logic [7:0] ST_OK   = 8'h00;
    localparam logic [7:0] ST_CHK  = 8'h01;
    localparam logic [7:0] ST_CMD  = 8'h02;

    typedef enum logic [2:0] {
        S_HUNT,
        S_FETCH,
        S_CAPT,
        S_EXEC,
        S_RWAIT,
        S_SEND
    } state_t;

endpackage

// File: rtl/uart_cmd_resp.sv
// Pulls 6-byte request frames from the RX FIFO, does one 16-bit register
// access, and pushes a 6-byte response frame into the TX FIFO.
module uart_cmd_resp
    import uart_cmd_resp_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000,
    parameter int TO_W        = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_fifo_empty,
    output logic        rx_fifo_ren,
    input  logic [7:0]  rx_fifo_rdata,
    input  logic        tx_fifo_full,
    output logic        tx_fifo_wen,
    output logic [7:0]  tx_fifo_wdata,
    output logic        reg_wen,
    output logic        reg_ren,
    output logic [7:0]  reg_addr,
    output logic [15:0] reg_wdata,
    input  logic [15:0] reg_rdata,
    output logic        frame_err
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    state_t          state;
    logic            live;
    logic [2:0]      idx;
    logic [5:1][7:0] fbuf;
    logic [7:0]      acc;
    logic [TO_W-1:0] to_cnt;
    logic [2:0]      k;
    logic [7:0]      status;
    logic [15:0]     rsp_d;
    logic [7:0]      tx_byte;

    logic chk_ok, cmd_wr, cmd_rd;

    assign chk_ok = (acc == fbuf[5]);
    assign cmd_wr = (fbuf[1] == CMD_WR);
    assign cmd_rd = (fbuf[1] == CMD_RD);

    // Strobes are gated by FIFO flags in the same cycle so a byte costs
    // exactly ren + capture; live keeps ren low while reset is applied.
    assign rx_fifo_ren = live && !rx_fifo_empty && (state == S_HUNT || state == S_FETCH);
    assign tx_fifo_wen = (state == S_SEND) && !tx_fifo_full;
    assign reg_wen     = (state == S_EXEC) && chk_ok && cmd_wr;
    assign reg_ren     = (state == S_EXEC) && chk_ok && cmd_rd;
    assign reg_addr    = fbuf[2];
    assign reg_wdata   = {fbuf[3], fbuf[4]};

    always_comb begin
        tx_byte = 8'h00;
        case (k)
            3'd0:    tx_byte = HDR_RSP;
            3'd1:    tx_byte = status;
            3'd2:    tx_byte = fbuf[2];
            3'd3:    tx_byte = rsp_d[15:8];
            3'd4:    tx_byte = rsp_d[7:0];
            default: tx_byte = status ^ fbuf[2] ^ rsp_d[15:8] ^ rsp_d[7:0];
        endcase
    end

    assign tx_fifo_wdata = tx_fifo_wen ? tx_byte : 8'h00;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_HUNT;
            live      <= 1'b0;
            idx       <= '0;
            fbuf      <= '0;
            acc       <= '0;
            to_cnt    <= '0;
            k         <= '0;
            status    <= '0;
            rsp_d     <= '0;
            frame_err <= 1'b0;
        end else begin
            live      <= 1'b1;
            frame_err <= 1'b0;
            case (state)
                S_HUNT: begin
                    if (rx_fifo_ren) begin
                        idx   <= '0;
                        state <= S_CAPT;
                    end
                end
                S_FETCH: begin
                    if (rx_fifo_ren) begin
                        state <= S_CAPT;
                    end else if (to_cnt == TO_LAST) begin
                        state     <= S_HUNT;
                        frame_err <= 1'b1;
                        idx       <= '0;
                        to_cnt    <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_CAPT: begin
                    to_cnt <= '0;
                    if (idx == 3'd0) begin
                        // Only the header byte is checked here; A5 inside a frame is data.
                        if (rx_fifo_rdata == HDR_REQ) begin
                            idx   <= 3'd1;
                            acc   <= '0;
                            state <= S_FETCH;
                        end else begin
                            state <= S_HUNT;
                        end
                    end else begin
                        for (int i = 1; i <= 5; i++)
                            if (idx == 3'(i)) fbuf[i] <= rx_fifo_rdata;
                        if (idx != 3'd5) acc <= acc ^ rx_fifo_rdata;
                        if (idx == 3'd5) begin
                            state <= S_EXEC;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= S_FETCH;
                        end
                    end
                end
                S_EXEC: begin
                    rsp_d <= {fbuf[3], fbuf[4]};
                    k     <= '0;
                    if (!chk_ok)               status <= ST_CHK;
                    else if (!cmd_wr && !cmd_rd) status <= ST_CMD;
                    else                       status <= ST_OK;
                    state <= (chk_ok && cmd_rd) ? S_RWAIT : S_SEND;
                end
                S_RWAIT: begin
                    rsp_d <= reg_rdata;
                    state <= S_SEND;
                end
                S_SEND: begin
                    if (!tx_fifo_full) begin
                        if (k == 3'd5) begin
                            k     <= '0;
                            idx   <= '0;
                            state <= S_HUNT;
                        end else begin
                            k <= k + 3'd1;
                        end
                    end
                end
                default: state <= S_HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_resp.sv
// Directed bench: FIFO and register-bus models around uart_cmd_resp.
module tb_uart_cmd_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_fifo_empty;
    logic        rx_fifo_ren;
    logic [7:0]  rx_fifo_rdata;
    logic        tx_fifo_full;
    logic        tx_fifo_wen;
    logic [7:0]  tx_fifo_wdata;
    logic        reg_wen;
    logic        reg_ren;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic [15:0] reg_rdata;
    logic        frame_err;

    uart_cmd_resp #(.TIMEOUT_CYC(40), .TO_W(6)) dut (
        .clk(clk), .rst(rst),
        .rx_fifo_empty(rx_fifo_empty), .rx_fifo_ren(rx_fifo_ren), .rx_fifo_rdata(rx_fifo_rdata),
        .tx_fifo_full(tx_fifo_full), .tx_fifo_wen(tx_fifo_wen), .tx_fifo_wdata(tx_fifo_wdata),
        .reg_wen(reg_wen), .reg_ren(reg_ren), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [47:0] rx;
        logic [15:0] rd;
        logic [47:0] tx;
        int          n_wen;
        int          n_ren;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } vec_t;

    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    int   n_chk = 0, n_fail = 0;
    int   n_wen = 0, n_ren = 0, n_ferr = 0;
    logic [7:0]  last_addr;
    logic [15:0] last_wdata;
    logic [15:0] rd_val = 16'h0;
    logic pop_req = 1'b0, rd_pend = 1'b0;

    // Mid-cycle monitor: strobes are stable here.
    always @(negedge clk) begin
        pop_req = rx_fifo_ren;
        if (rx_fifo_ren && rx_fifo_empty) begin
            n_fail++;
            $display("FAIL rx_ren_while_empty: ren=1 empty=1 at %0t", $time);
        end
        if (tx_fifo_wen) begin
            if (tx_fifo_full) begin
                n_fail++;
                $display("FAIL tx_wen_while_full: wen=1 full=1 at %0t", $time);
            end
            txq.push_back(tx_fifo_wdata);
        end
        if (reg_wen) begin n_wen++; last_addr = reg_addr; last_wdata = reg_wdata; end
        if (reg_ren) begin n_ren++; last_addr = reg_addr; rd_pend = 1'b1; end
        if (frame_err) n_ferr++;
    end

    // FIFO read data and register read data follow their strobes by one cycle.
    always @(posedge clk) begin
        #1;
        if (pop_req && rxq.size() > 0) rx_fifo_rdata = rxq.pop_front();
        rx_fifo_empty = (rxq.size() == 0);
        reg_rdata = rd_pend ? rd_val : 16'h0000;
        rd_pend = 1'b0;
        pop_req = 1'b0;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [47:0] b, input int n);
        for (int i = 0; i < n; i++) rxq.push_back(b[47-8*i -: 8]);
        rx_fifo_empty = (rxq.size() == 0);
    endtask

    task automatic clr();
        txq.delete();
        n_wen = 0; n_ren = 0; n_ferr = 0;
    endtask

    task automatic wait_tx(input int n, input int budget, input string name);
        int c = 0;
        while (txq.size() < n && c < budget) begin step(1); c++; end
        if (txq.size() < n) begin
            n_fail++;
            $display("FAIL %s_wait: got %0d tx bytes expected %0d", name, txq.size(), n);
        end
    endtask

    function automatic logic [47:0] tx_frame();
        logic [47:0] f = '0;
        for (int i = 0; i < 6 && i < txq.size(); i++) f[47-8*i -: 8] = txq[i];
        return f;
    endfunction

    task automatic check_frame(input vec_t v, input int exp_ferr);
        chk({v.name, "_tx"}, 64'(tx_frame()), 64'(v.tx));
        chk({v.name, "_txcnt"}, 64'(txq.size()), 64'd6);
        chk({v.name, "_wen"}, 64'(n_wen), 64'(v.n_wen));
        chk({v.name, "_ren"}, 64'(n_ren), 64'(v.n_ren));
        chk({v.name, "_ferr"}, 64'(n_ferr), 64'(exp_ferr));
        if (v.n_wen + v.n_ren > 0) chk({v.name, "_addr"}, 64'(last_addr), 64'(v.addr));
        if (v.n_wen > 0) chk({v.name, "_wdata"}, 64'(last_wdata), 64'(v.wdata));
    endtask

    task automatic run_vec(input vec_t v);
        rd_val = v.rd;
        push(v.rx, 6);
        wait_tx(6, 100, v.name);
        step(5);
        check_frame(v, 0);
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{"write",  48'hA5_01_10_12_34_37, 16'h0000, 48'h5A_00_10_12_34_36, 1, 0, 8'h10, 16'h1234};
        vecs[1] = '{"read",   48'hA5_02_20_00_00_22, 16'hBEEF, 48'h5A_00_20_BE_EF_71, 0, 1, 8'h20, 16'h0000};
        vecs[2] = '{"chkerr", 48'hA5_01_10_12_34_00, 16'h0000, 48'h5A_01_10_12_34_37, 0, 0, 8'h00, 16'h0000};
        vecs[3] = '{"badcmd", 48'hA5_07_10_12_34_31, 16'h0000, 48'h5A_02_10_12_34_34, 0, 0, 8'h00, 16'h0000};

        rst = 1'b0; tx_fifo_full = 1'b0; rx_fifo_empty = 1'b1;
        rx_fifo_rdata = 8'h00; reg_rdata = 16'h0000;
        step(3);
        chk("reset_outputs",
            64'({rx_fifo_ren, tx_fifo_wen, tx_fifo_wdata, reg_wen, reg_ren, reg_addr, reg_wdata, frame_err}), 64'd0);
        rst = 1'b1;
        step(2);

        for (int i = 0; i < 4; i++) begin
            clr();
            run_vec(vecs[i]);
        end

        // Junk bytes before the header are dropped silently.
        clr();
        push(48'h00FF_0000_0000, 2);
        run_vec(vecs[0]);

        // Inter-byte gap below the timeout must not abandon the frame.
        clr();
        push(48'hA5_01_10_00_00_00, 3);
        step(30);
        push(48'h12_34_37_00_00_00, 3);
        wait_tx(6, 100, "gap");
        step(5);
        check_frame('{"gap", 48'h0, 16'h0, 48'h5A_00_10_12_34_36, 1, 0, 8'h10, 16'h1234}, 0);

        // Starved frame times out: one error pulse, no response.
        clr();
        push(48'hA5_01_00_00_00_00, 2);
        step(60);
        chk("timeout_ferr", 64'(n_ferr), 64'd1);
        chk("timeout_txcnt", 64'(txq.size()), 64'd0);
        chk("timeout_wen", 64'(n_wen), 64'd0);
        clr();
        run_vec(vecs[0]);

        // TX backpressure for 5 cycles partway through the response.
        clr();
        rd_val = 16'h0;
        push(vecs[0].rx, 6);
        wait_tx(2, 100, "bp_pre");
        tx_fifo_full = 1'b1;
        step(5);
        chk("bp_stalled", 64'(txq.size()), 64'd2);
        tx_fifo_full = 1'b0;
        wait_tx(6, 100, "bp");
        step(5);
        check_frame(vecs[0], 0);

        // Reset in the middle of SEND; response is not resumed afterwards.
        clr();
        push(vecs[0].rx, 6);
        wait_tx(3, 100, "rst_pre");
        rst = 1'b0;
        #1;
        chk("midsend_rst_outputs",
            64'({rx_fifo_ren, tx_fifo_wen, tx_fifo_wdata, reg_wen, reg_ren, reg_addr, reg_wdata, frame_err}), 64'd0);
        step(2);
        rst = 1'b1;
        step(20);
        chk("midsend_no_resume", 64'(txq.size()), 64'd3);
        clr();
        run_vec(vecs[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/uart_cmd_resp.md
# uart_cmd_resp

Host-facing command responder sitting on the `clk_h` side of the UART top, at the far end of its RX/TX FIFOs. It pulls request frames from the UART RX FIFO, validates them, and performs one 16-bit register write or read on a simple register bus. It then pushes a fixed-length response frame into the UART TX FIFO. This turns the raw byte pipe into the register-access path for the acquisition design.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 100000: maximum `clk` cycles allowed between two bytes of one request before the frame is abandoned.
- `TO_W`, default 17: width of the inter-byte timeout counter. Must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- `clk`  in  1: single clock, same as the UART FIFO user-side clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `rx_fifo_empty`  in  1: UART RX FIFO empty.
- `rx_fifo_ren`  out  1: RX FIFO read strobe.
- `rx_fifo_rdata`  in  8: RX FIFO data, valid the cycle after `rx_fifo_ren`.
- `tx_fifo_full`  in  1: UART TX FIFO full.
- `tx_fifo_wen`  out  1: TX FIFO write strobe.
- `tx_fifo_wdata`  out  8: TX FIFO write data.
- `reg_wen`  out  1: register write pulse, one cycle.
- `reg_ren`  out  1: register read pulse, one cycle.
- `reg_addr`  out  8: register address, held from EXEC until the next frame.
- `reg_wdata`  out  16: register write data.
- `reg_rdata`  in  16: register read data, valid exactly one cycle after `reg_ren`.
- `frame_err`  out  1: one-cycle pulse when a frame is dropped on timeout.

## Operation
- Request frame, 6 bytes: `A5`, cmd, addr, data_hi, data_lo, chk. chk is the XOR of cmd..data_lo.
- cmd values: `01` = write, `02` = read. For a read, the data bytes are don't-care but still enter the checksum.
- Response frame, 6 bytes: `5A`, status, addr, d_hi, d_lo, chk. chk is the XOR of status..d_lo.
  - status `00` = OK, `01` = checksum error, `02` = unknown cmd.
  - On a write, and on any error, the response d echoes the request data.
  - On a read, the response d is `reg_rdata`.
- State machine states: HUNT, FETCH, CAPT, EXEC, RWAIT, SEND.
- HUNT: assert `rx_fifo_ren` when `!rx_fifo_empty`. Next cycle, if the byte is `A5` go to FETCH with idx=1; otherwise stay in HUNT. Non-header bytes are discarded silently.
- FETCH/CAPT: FETCH asserts `ren` when not empty. CAPT stores the byte into `buf[idx]` and increments idx. After idx=5 is captured, go to EXEC.
- EXEC, evaluated in priority order:
  - checksum mismatch → status 01, no bus access;
  - otherwise bad cmd → status 02;
  - otherwise write → pulse `reg_wen`, go to SEND;
  - otherwise read → pulse `reg_ren`, go to RWAIT.
- RWAIT: latch `reg_rdata`, go to SEND.
- SEND: write response byte k (k = 0..5) on each cycle where `!tx_fifo_full`; `tx_fifo_wen` is held low while full. After byte 5 is written, go to HUNT.
- Timeout:
  - The counter clears on every captured byte and counts while in FETCH.
  - Reaching TIMEOUT_CYC returns the FSM to HUNT, pulses `frame_err`, and discards the partial frame.
  - No response is sent for a timed-out frame.
- An `A5` byte arriving mid-frame is treated as data; there is no resync inside a frame.
- Reset, asserted at any time including mid-frame or mid-SEND: state HUNT, all outputs 0, counters and buffer cleared. A partially sent response is not resumed.

## Timing
- RX byte cost: 2 cycles (ren, capture) when the FIFO is non-empty. A full request takes at least 12 cycles.
- Last capture → bus access pulse: 1 cycle (EXEC).
- Read: `reg_rdata` is sampled 1 cycle after `reg_ren`.
- SEND: 6 consecutive `tx_fifo_wen` cycles when the TX FIFO never fills. Each full cycle adds one stall cycle.
- `rx_fifo_ren` is never asserted while `rx_fifo_empty` is high. `tx_fifo_wen` is never asserted while `tx_fifo_full` is high.
- No RX reads occur during EXEC, RWAIT or SEND; one request is outstanding at a time.

## Structure
- A shared package holds the constants HDR_REQ=`A5`, HDR_RSP=`5A`, CMD_WR, CMD_RD, ST_OK, ST_CHK, ST_CMD, and the state encoding.
- No sub-modules are needed; the block is one FSM plus a 6-byte buffer, an XOR accumulator and a timeout counter.

## Test plan
- Write request: RX `A5 01 10 12 34 37` → `reg_wen` pulses once with addr `10` and wdata `1234`; TX gets `5A 00 10 12 34 36`.
- Read request: RX `A5 02 20 00 00 22`, with `reg_rdata`=`BEEF` → `reg_ren` pulses once; TX gets `5A 00 20 BE EF 71`.
- Errors:
  - RX `A5 01 10 12 34 00` → no `reg_wen`; TX gets `5A 01 10 12 34 37`.
  - RX `A5 07 10 12 34 31` → no bus access; TX gets `5A 02 10 12 34 34`.
- Resync: RX `00 FF` followed by the write frame above → identical response to the write scenario, and no `frame_err`.
- Timeout: RX `A5 01`, then the FIFO stays empty for more than TIMEOUT_CYC cycles → exactly one `frame_err` pulse and no TX writes. A following valid frame then gets a correct response.
- Backpressure and reset:
  - Hold `tx_fifo_full` high for 5 cycles during SEND → all 6 bytes are still written in order, and no `wen` occurs while full.
  - Assert reset mid-SEND → all outputs go to 0 and the FSM returns to HUNT.
